// File: rtl/cpu_fetch_unit.sv
// cpu_fetch_unit: instruction fetch stage with a single-entry holding register.
// Latency: request issued the cycle after IDLE/consume; instruction presented the cycle after imem_ack.
// Backpressure: id_stall holds the instruction in HOLD; no new request is issued until it is consumed.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   imem_req/imem_addr    read request and byte address (stable until imem_ack)
//   imem_rdata/imem_ack   returned instruction word and single-cycle completion pulse
//   id_stall              decode cannot accept the held instruction this cycle
//   jump_en/jump_addr     jump redirect (word target) applied on consumption
//   branch_en/branch_offset taken-branch redirect (byte offset) applied on consumption
//   if_instr/if_opcode/if_pc_plus2/if_valid  held instruction presented to decode
module cpu_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        id_stall,
  input  logic        jump_en,
  input  logic [12:0] jump_addr,
  input  logic        branch_en,
  input  logic [15:0] branch_offset,
  output logic [15:0] if_instr,
  output logic [2:0]  if_opcode,
  output logic [15:0] if_pc_plus2,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_plus2_q, pc_plus2_d;

  logic fetch_done;
  logic consume;

  // Ack only counts while a request is outstanding; stall only matters while holding.
  assign fetch_done = (state_q == S_REQ) && imem_ack;
  assign consume    = (state_q == S_HOLD) && !id_stall;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   if (fetch_done) state_d = S_HOLD;
      S_HOLD:  if (consume) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req = (state_q == S_REQ);
    if_valid = (state_q == S_HOLD);
  end

  // Datapath next-state: pc advances on fetch completion, redirects on consumption.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    if (fetch_done) begin
      instr_d    = imem_rdata;
      pc_plus2_d = pc_q + 16'd2;   // wraps 16'hFFFE -> 16'h0000
      pc_d       = pc_q + 16'd2;
    end else if (consume) begin
      if (jump_en) begin
        // Jump target keeps the top two bits of the sequential address (region-relative).
        pc_d = {pc_plus2_q[15:14], jump_addr, 1'b0};
      end else if (branch_en) begin
        pc_d = pc_plus2_q + branch_offset;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      instr_q    <= 16'h0000;
      pc_plus2_q <= 16'h0000;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus2_q <= pc_plus2_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_instr    = instr_q;
  assign if_opcode   = instr_q[15:13];
  assign if_pc_plus2 = pc_plus2_q;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
module tb_cpu_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic        id_stall;
  logic        jump_en;
  logic [12:0] jump_addr;
  logic        branch_en;
  logic [15:0] branch_offset;
  logic [15:0] if_instr;
  logic [2:0]  if_opcode;
  logic [15:0] if_pc_plus2;
  logic        if_valid;

  int checks   = 0;
  int failures = 0;

  cpu_fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ack      (imem_ack),
    .id_stall      (id_stall),
    .jump_en       (jump_en),
    .jump_addr     (jump_addr),
    .branch_en     (branch_en),
    .branch_offset (branch_offset),
    .if_instr      (if_instr),
    .if_opcode     (if_opcode),
    .if_pc_plus2   (if_pc_plus2),
    .if_valid      (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------
  // Behavioural model: a fetcher is either booting, waiting on memory,
  // or holding one instruction for decode.
  // ---------------------------------------------------------------
  bit          m_known = 1'b0;
  bit          m_boot;
  bit          m_waiting;
  bit          m_holding;
  logic [15:0] m_pc, m_instr, m_pcp2;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_known   = 1'b1;
      m_boot    = 1'b1;
      m_waiting = 1'b0;
      m_holding = 1'b0;
      m_pc      = 16'h0000;
      m_instr   = 16'h0000;
      m_pcp2    = 16'h0000;
    end else if (m_known) begin
      if (m_boot) begin
        m_boot    = 1'b0;
        m_waiting = 1'b1;
      end else if (m_waiting) begin
        if (imem_ack) begin
          m_instr   = imem_rdata;
          m_pcp2    = m_pc + 16'd2;
          m_pc      = m_pcp2;
          m_waiting = 1'b0;
          m_holding = 1'b1;
        end
      end else if (m_holding && !id_stall) begin
        m_holding = 1'b0;
        m_waiting = 1'b1;
        if (jump_en)
          m_pc = (m_pcp2 & 16'hC000) | (16'(jump_addr) * 16'd2);
        else if (branch_en)
          m_pc = m_pcp2 + branch_offset;
      end
    end
  end

  // Compare process: every cycle once the model is initialised by reset.
  always @(negedge clk) begin
    if (m_known) begin
      cmp("cyc_imem_req",  16'(imem_req), 16'(m_waiting));
      cmp("cyc_imem_addr", imem_addr, m_pc);
      cmp("cyc_if_valid",  16'(if_valid), 16'(m_holding));
      if (m_holding) begin
        cmp("cyc_if_instr",    if_instr, m_instr);
        cmp("cyc_if_opcode",   16'(if_opcode), 16'(m_instr[15:13]));
        cmp("cyc_if_pc_plus2", if_pc_plus2, m_pcp2);
      end
    end
  end

  // At a negedge in REQ: ack immediately, land in HOLD, check held values.
  task automatic do_fetch(input logic [15:0] data, input logic [15:0] exp_pcp2);
    #1;
    imem_ack   = 1'b1;
    imem_rdata = data;
    jump_en    = 1'b0;
    branch_en  = 1'b0;
    @(negedge clk);
    cmp("fetch_valid", 16'(if_valid), 16'h0001);
    cmp("fetch_instr", if_instr, data);
    cmp("fetch_pcp2",  if_pc_plus2, exp_pcp2);
  endtask

  // At a negedge in HOLD: consume with the given redirect, check next request.
  task automatic consume(input logic j, input logic [12:0] ja, input logic b,
                         input logic [15:0] bo, input logic [15:0] exp_addr);
    #1;
    imem_ack      = 1'b0;
    id_stall      = 1'b0;
    jump_en       = j;
    jump_addr     = ja;
    branch_en     = b;
    branch_offset = bo;
    @(negedge clk);
    cmp("next_req",  16'(imem_req), 16'h0001);
    cmp("next_addr", imem_addr, exp_addr);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000; id_stall = 1'b0;
    jump_en = 1'b0; jump_addr = 13'h0000; branch_en = 1'b0; branch_offset = 16'h0000;

    repeat (2) @(negedge clk);
    cmp("rst_req",   16'(imem_req), 16'h0000);
    cmp("rst_addr",  imem_addr, 16'h0000);
    cmp("rst_valid", 16'(if_valid), 16'h0000);
    cmp("rst_instr", if_instr, 16'h0000);
    cmp("rst_pcp2",  if_pc_plus2, 16'h0000);

    // First fetch, acked in the first REQ cycle; decode stalls on it.
    #1 rst_n = 1'b1;
    @(negedge clk);
    cmp("first_req",  16'(imem_req), 16'h0001);
    cmp("first_addr", imem_addr, 16'h0000);
    #1 imem_ack = 1'b1; imem_rdata = 16'h2345; id_stall = 1'b1;
    @(negedge clk);
    cmp("first_valid",  16'(if_valid), 16'h0001);
    cmp("first_instr",  if_instr, 16'h2345);
    cmp("first_opcode", 16'(if_opcode), 16'h0001);
    cmp("first_pcp2",   if_pc_plus2, 16'h0002);
    // Stray ack and redirects during a stall must be ignored.
    #1 imem_ack = 1'b1; imem_rdata = 16'hFFFF;
    jump_en = 1'b1; jump_addr = 13'h1ABC; branch_en = 1'b1; branch_offset = 16'h0100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmp("stall_valid", 16'(if_valid), 16'h0001);
      cmp("stall_instr", if_instr, 16'h2345);
      cmp("stall_req",   16'(imem_req), 16'h0000);
      #1 imem_ack = 1'b0;
    end
    consume(1'b0, 13'h0000, 1'b0, 16'h0000, 16'h0002);

    // Reset with a request outstanding; acks during and just after reset ignored.
    #1 rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h7777;
    @(negedge clk);
    cmp("abort_req",   16'(imem_req), 16'h0000);
    cmp("abort_valid", 16'(if_valid), 16'h0000);
    cmp("abort_addr",  imem_addr, 16'h0000);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    cmp("refetch_req",   16'(imem_req), 16'h0001);
    cmp("refetch_addr",  imem_addr, 16'h0000);
    cmp("refetch_valid", 16'(if_valid), 16'h0000);
    #1 imem_ack = 1'b0;

    // Ack delayed by three cycles: request and address stay put.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("delay_req",  16'(imem_req), 16'h0001);
      cmp("delay_addr", imem_addr, 16'h0000);
    end
    do_fetch(16'h4123, 16'h0002);
    consume(1'b0, 13'h0000, 1'b0, 16'h0000, 16'h0002);

    // Branch to 0x4000, then jump vs branch priority.
    do_fetch(16'h1111, 16'h0004);
    consume(1'b0, 13'h0000, 1'b1, 16'h3FFC, 16'h4000);
    do_fetch(16'h2222, 16'h4002);
    consume(1'b1, 13'h0100, 1'b1, 16'h1234, 16'h4200);

    // Backward branch and pc wrap.
    do_fetch(16'h3333, 16'h4202);
    consume(1'b0, 13'h0000, 1'b1, 16'hBE0C, 16'h000E);
    do_fetch(16'hE000, 16'h0010);
    consume(1'b0, 13'h0000, 1'b1, 16'hFFF8, 16'h0008);
    do_fetch(16'h5555, 16'h000A);
    consume(1'b0, 13'h0000, 1'b1, 16'hFFF4, 16'hFFFE);
    do_fetch(16'hA5A5, 16'h0000);
    consume(1'b0, 13'h0000, 1'b0, 16'h0000, 16'h0000);

    #1 imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
